// File: rtl/pcie_pipe_link_model.sv
`default_nettype none
// pcie_pipe_link_model : bidirectional multi-lane PIPE channel with per-lane skew,
// elecidle propagation, link gating and one-shot symbol error injection. Rev 1.0
module pcie_pipe_link_model #(
  parameter int LANES    = 1,
  parameter int DELAY    = 1,
  parameter int MAX_SKEW = 7,
  parameter int SKW      = 4
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic [8*LANES-1:0]    dn_tx_data,
  input  logic [LANES-1:0]      dn_tx_datak,
  input  logic                  dn_tx_elecidle,
  input  logic [8*LANES-1:0]    up_tx_data,
  input  logic [LANES-1:0]      up_tx_datak,
  input  logic                  up_tx_elecidle,
  output logic [8*LANES-1:0]    dn_rx_data,
  output logic [LANES-1:0]      dn_rx_datak,
  output logic                  dn_rx_elecidle,
  output logic [8*LANES-1:0]    up_rx_data,
  output logic [LANES-1:0]      up_rx_datak,
  output logic                  up_rx_elecidle,
  input  logic                  link_en,
  input  logic [SKW*LANES-1:0]  skew_cfg,
  input  logic                  inj_req,
  input  logic                  inj_dir,
  input  logic [3:0]            inj_lane,
  input  logic [7:0]            inj_mask,
  output logic [15:0]           inj_cnt
);

  localparam int DEPTH = DELAY + MAX_SKEW;
  localparam int TW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Direction index 0 = downstream (RC -> EP), 1 = upstream (EP -> RC)
  logic [1:0][8*LANES-1:0] tx_data;
  logic [1:0][LANES-1:0]   tx_datak;
  logic [1:0]              tx_ei;
  logic [1:0][8*LANES-1:0] rx_data;
  logic [1:0][LANES-1:0]   rx_datak;
  logic [1:0]              rx_ei;
  logic                    inj_hit;
  logic [15:0]             cnt;

  assign tx_data  = {up_tx_data, dn_tx_data};
  assign tx_datak = {up_tx_datak, dn_tx_datak};
  assign tx_ei    = {up_tx_elecidle, dn_tx_elecidle};

  assign inj_hit = inj_req && (32'(inj_lane) < LANES);

  for (genvar d = 0; d < 2; d++) begin : g_dir
    logic [DELAY-1:0] ei_line;
    logic             idle;

    always_ff @(posedge pclk) begin
      if (reset) begin
        ei_line <= '1;
      end else begin
        ei_line[0] <= tx_ei[d];
        for (int k = 1; k < DELAY; k++) ei_line[k] <= ei_line[k-1];
      end
    end

    assign idle     = !link_en || ei_line[DELAY-1];
    assign rx_ei[d] = idle;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [8:0]     sym_line [DEPTH];
      logic [SKW-1:0] skew_raw;
      logic [TW-1:0]  tap;
      logic [7:0]     in_data;
      logic [8:0]     tap_sym;

      assign skew_raw = skew_cfg[SKW*i +: SKW];

      always_comb begin
        in_data = tx_data[d][8*i +: 8];
        if (inj_hit && (inj_dir == 1'(d)) && (inj_lane == 4'(i)))
          in_data = in_data ^ inj_mask;
        // Entry k holds the symbol accepted k+1 edges ago, hence the -1
        if (32'(skew_raw) > MAX_SKEW) tap = TW'(DEPTH - 1);
        else                          tap = TW'(DELAY - 1 + 32'(skew_raw));
      end

      always_ff @(posedge pclk) begin
        if (reset) begin
          for (int k = 0; k < DEPTH; k++) sym_line[k] <= '0;
        end else begin
          sym_line[0] <= {tx_datak[d][i], in_data};
          for (int k = 1; k < DEPTH; k++) sym_line[k] <= sym_line[k-1];
        end
      end

      assign tap_sym               = sym_line[tap];
      assign rx_data[d][8*i +: 8]  = idle ? 8'h00 : tap_sym[7:0];
      assign rx_datak[d][i]        = !idle && tap_sym[8];
    end
  end

  always_ff @(posedge pclk) begin
    if (reset)                            cnt <= '0;
    else if (inj_hit && cnt != 16'hFFFF)  cnt <= cnt + 16'd1;
  end

  assign dn_rx_data     = rx_data[0];
  assign dn_rx_datak    = rx_datak[0];
  assign dn_rx_elecidle = rx_ei[0];
  assign up_rx_data     = rx_data[1];
  assign up_rx_datak    = rx_datak[1];
  assign up_rx_elecidle = rx_ei[1];
  assign inj_cnt        = cnt;

endmodule
`default_nettype wire

// File: tb/tb_pcie_pipe_link_model.sv
`default_nettype none
// tb_pcie_pipe_link_model : scoreboard bench for the PIPE link channel model.
module tb_pcie_pipe_link_model;

  localparam int LANES    = 4;
  localparam int DELAY    = 2;
  localparam int MAX_SKEW = 7;
  localparam int SKW      = 4;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic                 reset;
  logic [8*LANES-1:0]   dn_tx_data, up_tx_data, dn_rx_data, up_rx_data;
  logic [LANES-1:0]     dn_tx_datak, up_tx_datak, dn_rx_datak, up_rx_datak;
  logic                 dn_tx_elecidle, up_tx_elecidle, dn_rx_elecidle, up_rx_elecidle;
  logic                 link_en;
  logic [SKW*LANES-1:0] skew_cfg;
  logic                 inj_req, inj_dir;
  logic [3:0]           inj_lane;
  logic [7:0]           inj_mask;
  logic [15:0]          inj_cnt;

  pcie_pipe_link_model #(
    .LANES(LANES), .DELAY(DELAY), .MAX_SKEW(MAX_SKEW), .SKW(SKW)
  ) dut (
    .pclk(pclk), .reset(reset),
    .dn_tx_data(dn_tx_data), .dn_tx_datak(dn_tx_datak), .dn_tx_elecidle(dn_tx_elecidle),
    .up_tx_data(up_tx_data), .up_tx_datak(up_tx_datak), .up_tx_elecidle(up_tx_elecidle),
    .dn_rx_data(dn_rx_data), .dn_rx_datak(dn_rx_datak), .dn_rx_elecidle(dn_rx_elecidle),
    .up_rx_data(up_rx_data), .up_rx_datak(up_rx_datak), .up_rx_elecidle(up_rx_elecidle),
    .link_en(link_en), .skew_cfg(skew_cfg),
    .inj_req(inj_req), .inj_dir(inj_dir), .inj_lane(inj_lane), .inj_mask(inj_mask),
    .inj_cnt(inj_cnt)
  );

  typedef struct packed { int unsigned due; logic k; logic [7:0] d; } sym_t;
  typedef struct packed { int unsigned due; logic ei; } ei_t;

  sym_t sq [2][LANES][$];
  ei_t  eq [2][$];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  logic [15:0] exp_cnt;
  logic        cur_link;

  // Staged stimulus, applied right after the next sampling point
  logic [1:0][8*LANES-1:0] n_data;
  logic [1:0][LANES-1:0]   n_k;
  logic [1:0]              n_ei;
  logic                    n_reset, n_link, n_inj_req, n_inj_dir;
  logic [3:0]              n_inj_lane;
  logic [7:0]              n_mask;
  logic [SKW*LANES-1:0]    n_skew;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    int unsigned sk;
    logic [7:0]  b;
    sym_t        s;
    ei_t         e;
    reset = n_reset;  link_en = n_link;  skew_cfg = n_skew;
    dn_tx_data = n_data[0];  dn_tx_datak = n_k[0];  dn_tx_elecidle = n_ei[0];
    up_tx_data = n_data[1];  up_tx_datak = n_k[1];  up_tx_elecidle = n_ei[1];
    inj_req = n_inj_req;  inj_dir = n_inj_dir;  inj_lane = n_inj_lane;  inj_mask = n_mask;
    cur_link = n_link;
    if (n_reset) begin
      for (int d = 0; d < 2; d++) begin
        eq[d].delete();
        for (int i = 0; i < LANES; i++) sq[d][i].delete();
      end
      exp_cnt = 16'h0000;
    end else begin
      for (int d = 0; d < 2; d++) begin
        e.due = cyc + DELAY;  e.ei = n_ei[d];
        eq[d].push_back(e);
        for (int i = 0; i < LANES; i++) begin
          sk = 32'(n_skew[SKW*i +: SKW]);
          if (sk > MAX_SKEW) sk = MAX_SKEW;
          b = n_data[d][8*i +: 8];
          if (n_inj_req && n_inj_lane < LANES && n_inj_dir == d[0] && n_inj_lane == i[3:0])
            b = b ^ n_mask;
          s.due = cyc + DELAY + sk;  s.k = n_k[d][i];  s.d = b;
          sq[d][i].push_back(s);
        end
      end
      if (n_inj_req && n_inj_lane < LANES && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  task automatic check_outputs();
    logic [1:0][8*LANES-1:0] rd;
    logic [1:0][LANES-1:0]   rk;
    logic [1:0]              rei;
    logic                    ei_exp, idle;
    sym_t                    s;
    rd  = {up_rx_data, dn_rx_data};
    rk  = {up_rx_datak, dn_rx_datak};
    rei = {up_rx_elecidle, dn_rx_elecidle};
    for (int d = 0; d < 2; d++) begin
      ei_exp = 1'b1;
      if (eq[d].size() > 0 && eq[d][0].due == cyc) begin
        ei_exp = eq[d][0].ei;
        void'(eq[d].pop_front());
      end
      idle = !cur_link || ei_exp;
      check($sformatf("elecidle dir%0d", d), 32'(rei[d]), 32'(idle));
      for (int i = 0; i < LANES; i++) begin
        s = '0;
        if (sq[d][i].size() > 0 && sq[d][i][0].due == cyc) s = sq[d][i].pop_front();
        check($sformatf("data dir%0d lane%0d", d, i), 32'(rd[d][8*i +: 8]),
              idle ? 32'h0 : 32'(s.d));
        check($sformatf("datak dir%0d lane%0d", d, i), 32'(rk[d][i]),
              32'(!idle && s.k));
      end
    end
    check("inj_cnt", 32'(inj_cnt), 32'(exp_cnt));
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    cyc++;
    check_outputs();
    drive();
  endtask

  task automatic set_all(input int d, input logic [7:0] b, input logic k);
    for (int i = 0; i < LANES; i++) n_data[d][8*i +: 8] = b;
    n_k[d] = {LANES{k}};
  endtask

  task automatic rand_traffic();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < LANES; i++) n_data[d][8*i +: 8] = 8'($urandom);
      n_k[d] = LANES'($urandom);
    end
  endtask

  initial begin
    n_reset = 1'b1;  n_link = 1'b1;  n_ei = 2'b11;  n_skew = '0;
    n_data = '0;  n_k = '0;
    n_inj_req = 1'b0;  n_inj_dir = 1'b0;  n_inj_lane = 4'd0;  n_mask = 8'h00;
    drive();
    repeat (3) step();

    // Basic latency: COM then 4A in both directions
    n_reset = 1'b0;  n_ei = 2'b00;
    set_all(0, 8'hBC, 1'b1);  set_all(1, 8'hBC, 1'b1);  step();
    set_all(0, 8'h4A, 1'b0);  set_all(1, 8'h4A, 1'b0);  step();
    repeat (20) begin rand_traffic(); step(); end

    // Per-lane skew {0,1,3,7}: COM on all lanes in one cycle
    n_reset = 1'b1;  n_skew = 16'h7310;  n_data = '0;  n_k = '0;  step();
    n_reset = 1'b0;  repeat (3) step();
    set_all(0, 8'hBC, 1'b1);  set_all(1, 8'hBC, 1'b1);  step();
    n_data = '0;  n_k = '0;
    repeat (20) step();

    // Skew field 15 clamps to MAX_SKEW
    n_reset = 1'b1;  n_skew = 16'hF310;  step();
    n_reset = 1'b0;
    repeat (30) begin rand_traffic(); step(); end

    // Upstream electrical idle for 5 cycles with FF on the wire
    n_ei[1] = 1'b1;  set_all(1, 8'hFF, 1'b0);
    repeat (5) step();
    n_ei[1] = 1'b0;
    repeat (12) begin rand_traffic(); step(); end

    // Error injection: dn lane 2 mask 01, then an out-of-range lane
    n_reset = 1'b1;  n_skew = '0;  step();
    n_reset = 1'b0;
    set_all(0, 8'h4A, 1'b0);  set_all(1, 8'h4A, 1'b0);
    n_inj_req = 1'b1;  n_inj_dir = 1'b0;  n_inj_lane = 4'd2;  n_mask = 8'h01;  step();
    n_inj_req = 1'b0;  repeat (3) step();
    n_inj_req = 1'b1;  n_inj_lane = 4'd5;  n_mask = 8'hFF;  step();
    n_inj_req = 1'b0;  repeat (3) step();
    repeat (40) begin
      rand_traffic();
      n_inj_req = 1'($urandom);  n_inj_dir = 1'($urandom);
      n_inj_lane = 4'($urandom_range(0, 7));  n_mask = 8'($urandom);
      step();
    end
    n_inj_req = 1'b0;

    // link_en dropped for 3 cycles during traffic
    n_skew = 16'h2130;
    n_reset = 1'b1;  step();
    n_reset = 1'b0;
    repeat (12) begin rand_traffic(); step(); end
    n_link = 1'b0;
    repeat (3) begin rand_traffic(); step(); end
    n_link = 1'b1;
    repeat (12) begin rand_traffic(); step(); end

    // One-cycle reset in the middle of traffic
    repeat (8) begin rand_traffic(); step(); end
    rand_traffic();  n_reset = 1'b1;  step();
    n_reset = 1'b0;
    repeat (15) begin rand_traffic(); step(); end

    // Counter saturation
    n_inj_req = 1'b1;
    repeat (70000) begin
      rand_traffic();
      n_inj_dir = 1'($urandom);  n_inj_lane = 4'($urandom_range(0, 3));  n_mask = 8'($urandom);
      step();
    end
    n_inj_req = 1'b0;
    repeat (12) step();
    check("inj_cnt saturated", 32'(inj_cnt), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
